// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage core: arbitrates memory wait,
// redirect and load-use, and keeps saturating stall/flush statistics and a sticky timeout.
module hazard_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 255,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             dmem_busy,
    output logic             IFWrite,
    output logic             IDWrite,
    output logic             ID_bubble,
    output logic             IF_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             timeout
);

    localparam int unsigned WAIT_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_t;

    state_t             state_q;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic [WAIT_W:0]    wait_inc;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   flush_cnt_q;
    logic               timeout_q;
    logic               redirect;
    logic               load_use;

    assign redirect = Branch | Jump;
    assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((ID_uses_rs1 && (EX_rd == ID_rs1)) ||
                       (ID_uses_rs2 && (EX_rd == ID_rs2)));
    assign wait_inc = {1'b0, wait_cnt_q} + (WAIT_W + 1)'(1);

    always_comb begin
        IFWrite   = 1'b1;
        IDWrite   = 1'b1;
        ID_bubble = 1'b0;
        IF_flush  = 1'b0;
        if (!reset) begin
            // Outputs held at pass-through while reset is asserted.
        end else if (state_q == StTimeout || dmem_busy) begin
            IFWrite = 1'b0;
            IDWrite = 1'b0;
        end else if (redirect) begin
            ID_bubble = 1'b1;
            IF_flush  = 1'b1;
        end else if (load_use) begin
            IFWrite   = 1'b0;
            IDWrite   = 1'b0;
            ID_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (!IFWrite && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IF_flush && flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            unique case (state_q)
                StRun: begin
                    if (dmem_busy) begin
                        wait_cnt_q <= WAIT_W'(1);
                        // A one-cycle limit trips on the very first busy edge.
                        if (STALL_TIMEOUT == 1) begin
                            state_q   <= StTimeout;
                            timeout_q <= 1'b1;
                        end else begin
                            state_q <= StMemWait;
                        end
                    end
                end
                StMemWait: begin
                    if (dmem_busy) begin
                        wait_cnt_q <= wait_inc[WAIT_W-1:0];
                        if (wait_inc == (WAIT_W + 1)'(STALL_TIMEOUT)) begin
                            state_q   <= StTimeout;
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        state_q    <= StRun;
                        wait_cnt_q <= '0;
                    end
                end
                StTimeout: begin
                    state_q <= StTimeout;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random stimulus,
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned TO  = 4;
    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_rs1, ID_rs2, EX_rd;
    logic          ID_uses_rs1, ID_uses_rs2, EX_MemRead, Branch, Jump, dmem_busy;
    logic          IFWrite, IDWrite, ID_bubble, IF_flush, timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_uses_rs1 (ID_uses_rs1),
        .ID_uses_rs2 (ID_uses_rs2),
        .EX_MemRead  (EX_MemRead),
        .EX_rd       (EX_rd),
        .Branch      (Branch),
        .Jump        (Jump),
        .dmem_busy   (dmem_busy),
        .IFWrite     (IFWrite),
        .IDWrite     (IDWrite),
        .ID_bubble   (ID_bubble),
        .IF_flush    (IF_flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ifw;
        bit idw;
        bit bub;
        bit fl;
        bit to;
        int stall;
        int flush;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: consecutive busy cycles seen, sticky timeout, statistics.
    int m_stall = 0, m_flush = 0, m_busy_run = 0;
    bit m_to = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("IFWrite",   int'(IFWrite),   int'(e.ifw));
            check("IDWrite",   int'(IDWrite),   int'(e.idw));
            check("ID_bubble", int'(ID_bubble), int'(e.bub));
            check("IF_flush",  int'(IF_flush),  int'(e.fl));
            check("timeout",   int'(timeout),   int'(e.to));
            check("stall_cnt", int'(stall_cnt), e.stall);
            check("flush_cnt", int'(flush_cnt), e.flush);
        end
    end

    task automatic drive(input bit rst, input bit bsy, input bit br, input bit jp,
                         input bit mr, input int rd, input int r1, input int r2,
                         input bit u1, input bit u2);
        exp_t e;
        bit   lu;
        reset       = rst;
        dmem_busy   = bsy;
        Branch      = br;
        Jump        = jp;
        EX_MemRead  = mr;
        EX_rd       = 5'(rd);
        ID_rs1      = 5'(r1);
        ID_rs2      = 5'(r2);
        ID_uses_rs1 = u1;
        ID_uses_rs2 = u2;
        if (!rst) begin
            m_stall = 0; m_flush = 0; m_busy_run = 0; m_to = 0;
        end
        lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
        e.to = m_to; e.stall = m_stall; e.flush = m_flush;
        e.ifw = 1; e.idw = 1; e.bub = 0; e.fl = 0;
        if (rst) begin
            if (m_to || bsy) begin
                e.ifw = 0; e.idw = 0;
            end else if (br || jp) begin
                e.bub = 1; e.fl = 1;
            end else if (lu) begin
                e.ifw = 0; e.idw = 0; e.bub = 1;
            end
        end
        q.push_back(e);
        if (rst) begin
            if (!e.ifw && m_stall < MAX) m_stall++;
            if (e.fl && m_flush < MAX) m_flush++;
            if (!m_to) begin
                if (bsy) begin
                    m_busy_run++;
                    if (m_busy_run >= TO) m_to = 1;
                end else begin
                    m_busy_run = 0;
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; dmem_busy = 0; Branch = 0; Jump = 0; EX_MemRead = 0;
        EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
        @(posedge clk);
        #2;
        // Reset held with every hazard input active: outputs stay pass-through.
        drive(0, 1, 1, 1, 1, 5, 5, 5, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Load-use, then the same with x0 as destination.
        drive(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 0, 0, 0, 1, 7, 3, 7, 0, 1);
        idle(1);
        // Redirect wins over load-use.
        drive(1, 0, 1, 0, 1, 5, 5, 0, 1, 0);
        idle(1);
        // Memory wait with a deferred jump.
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Timeout: sticky and frozen after busy drops, cleared by reset.
        for (int i = 0; i < 6; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 1, 5, 5, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Saturation of stall_cnt.
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 1, 9, 9, 9, 1, 1);
        idle(1);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Random traffic with narrow register indices to provoke matches.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 29) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        #1;
        check("scoreboard_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V core. It drives the fetch stage's `IFWrite` hold control and `IF_flush` squash, the IF/ID register enable and the ID/EX bubble insert. It arbitrates among three hazard sources: data-memory wait, branch/jump redirect and load-use. It also keeps saturating stall/flush statistics and a sticky timeout for a data memory that never completes.

## Interface

Parameters:
- `STALL_TIMEOUT`, default 255: number of consecutive `dmem_busy` cycles that trips the timeout; legal range 1..65535.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `ID_rs1`  in  5: rs1 field of the instruction in ID.
- `ID_rs2`  in  5: rs2 field of the instruction in ID.
- `ID_uses_rs1`  in  1: the ID instruction reads rs1.
- `ID_uses_rs2`  in  1: the ID instruction reads rs2.
- `EX_MemRead`  in  1: the instruction in EX is a load.
- `EX_rd`  in  5: destination register of the EX instruction.
- `Branch`  in  1: taken branch resolved in EX.
- `Jump`  in  1: jump resolved in EX.
- `dmem_busy`  in  1: the data memory has not completed the MEM-stage access.
- `IFWrite`  out  1: 1 = PC advances or loads; 0 = PC holds.
- `IDWrite`  out  1: 1 = IF/ID register loads; 0 = it holds.
- `ID_bubble`  out  1: 1 = ID/EX register loads a NOP.
- `IF_flush`  out  1: 1 = PC takes the jump target and IF/ID is squashed.
- `stall_cnt`  out  CNT_W: number of cycles with `IFWrite`=0, saturating.
- `flush_cnt`  out  CNT_W: number of cycles with `IF_flush`=1, saturating.
- `timeout`  out  1: sticky data-memory timeout flag.

## Operation

- State machine: `RUN`, `MEM_WAIT`, `TIMEOUT`.
- Hazard flags are combinational:
  - `redirect` = `Branch` | `Jump`.
  - `load_use` = `EX_MemRead` & (`EX_rd` != 0) & ((`ID_uses_rs1` & `EX_rd`==`ID_rs1`) | (`ID_uses_rs2` & `EX_rd`==`ID_rs2`)).
- Output priority in `RUN` and `MEM_WAIT` (Mealy outputs, highest first):
  1. `dmem_busy`=1: freeze. `IFWrite`=0, `IDWrite`=0, `ID_bubble`=0, `IF_flush`=0. Any redirect is deferred; the EX stage is frozen, so `Branch`/`Jump` stay asserted.
  2. `redirect`: `IFWrite`=1, `IDWrite`=1, `IF_flush`=1, `ID_bubble`=1. Redirect overrides load-use because the ID instruction is squashed anyway.
  3. `load_use`: `IFWrite`=0, `IDWrite`=0, `ID_bubble`=1, `IF_flush`=0.
  4. None of the above: `IFWrite`=1, `IDWrite`=1, `ID_bubble`=0, `IF_flush`=0.
- Transitions:
  - `RUN` → `MEM_WAIT` when `dmem_busy`=1. The internal run counter `wait_cnt` loads 1.
  - `MEM_WAIT` with `dmem_busy`=1: `wait_cnt` increments. When `wait_cnt` == `STALL_TIMEOUT`, go to `TIMEOUT`.
  - `MEM_WAIT` with `dmem_busy`=0: return to `RUN`. Outputs in that cycle follow priorities 2–4.
  - `TIMEOUT` is absorbing until reset. Outputs are frozen as in priority 1 regardless of inputs; `timeout`=1.
- Counters:
  - `stall_cnt` increments on every edge where `IFWrite`=0, including load-use, freeze and `TIMEOUT`.
  - `flush_cnt` increments on every edge where `IF_flush`=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - `wait_cnt` width is ceil(log2(STALL_TIMEOUT+1)) bits.

## Timing

- Hazard outputs are combinational: zero-cycle latency from input to output.
- State, `wait_cnt`, the counters and `timeout` are registered. `timeout` rises on the edge that completes `STALL_TIMEOUT` consecutive busy cycles.
- A load-use stall lasts exactly one cycle, provided the EX stage advances normally.
- Reset asserted (low) at any time, including mid-`MEM_WAIT` or in `TIMEOUT`:
  - State goes to `RUN` immediately and `wait_cnt`=0.
  - `stall_cnt`=0, `flush_cnt`=0, `timeout`=0.
  - While reset is low, outputs are forced to `IFWrite`=1, `IDWrite`=1, `ID_bubble`=0, `IF_flush`=0.
  - First evaluation happens on the first edge after reset is released.
- `EX_rd`=0 never causes a load-use stall (x0).
- Simultaneous `Branch` and `Jump` behave the same as either one alone.

## Test plan

- Load-use stall: `EX_MemRead`=1, `EX_rd`=5, `ID_rs1`=5, `ID_uses_rs1`=1 for one cycle.
  - Required: `IFWrite`=0, `IDWrite`=0, `ID_bubble`=1 for one cycle; `stall_cnt` 0→1.
  - Repeat with `EX_rd`=0: no stall.
- Redirect over load-use: `Branch`=1 together with a load-use match.
  - Required: `IF_flush`=1, `IFWrite`=1, `ID_bubble`=1; `flush_cnt`=1; `stall_cnt` unchanged.
- Memory wait with deferred redirect: `dmem_busy`=1 for 3 cycles with `Jump`=1 held.
  - Required: all control outputs 0 for 3 cycles, `stall_cnt`=3, then `IF_flush`=1 on the first cycle with `dmem_busy`=0.
- Timeout: `STALL_TIMEOUT`=4, hold `dmem_busy`=1.
  - Required: `timeout`=1 after the 4th edge; it stays 1 with outputs frozen after `dmem_busy` drops.
  - Asserting `reset` low clears `timeout` and `stall_cnt`.
- Saturation: `CNT_W`=4, 20 consecutive load-use cycles.
  - Required: `stall_cnt` holds at 15 and never wraps to 0.
